tick_period_monitor: RTL and testbench
======================================

# tick_period_monitor

Receive-side checker for the periodic one-cycle tick emitted by the mod-1000 clock divider. It measures the spacing between tick pulses in `clk` cycles and reports each measured period. It flags early and late or missing ticks and asserts a lock indication once the tick stream is stable. It sits downstream of the divider, in the same `clk` domain, and is used by timestamping logic to qualify the divided time base.

## Interface
Parameters:
- `EXP_PERIOD`, default 1000: expected tick spacing in `clk` cycles.
- `TOL`, default 2: accepted deviation, ± cycles.
- `LOCK_N`, default 4: consecutive good periods required to assert `locked`.
- `CNT_W`, default 12: width of the cycle counter and of `period`. Must hold `EXP_PERIOD+TOL+1`.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  monitor enable. Low forces the monitor to idle.
- `tick_in`  in  1  one-cycle tick pulse from the divider.
- `clear`  in  1  synchronous clear of `miss_count`.
- `period`  out  CNT_W  last measured period, held until the next measurement.
- `period_valid`  out  1  one-cycle strobe; `period` was updated.
- `err_short`  out  1  one-cycle strobe; the tick arrived early.
- `err_long`  out  1  one-cycle strobe; the tick is late or missing (timeout).
- `locked`  out  1  level; the tick stream is stable.
- `miss_count`  out  8  saturating count of timeouts.

## Operation
- States: `SYNC` (waiting for the first tick), `TRACK` (measuring, not locked), `LOCKED`.
- Counter `cnt`:
  - Cleared to 0 in any cycle with an accepted tick.
  - Otherwise increments by 1 each cycle while in `TRACK` or `LOCKED`.
- Measured period is `cnt+1` at the tick cycle, so ticks N cycles apart give `period`=N.
- `SYNC`: on `tick_in`, go to `TRACK` with `cnt`=0 and `good`=0. No period is reported.
- `TRACK` or `LOCKED`, on `tick_in` with measured value m:
  - m in [EXP_PERIOD-TOL, EXP_PERIOD+TOL]:
    - `period`=m and `period_valid` pulses.
    - `good` increments, saturating at `LOCK_N`.
    - `good` reaching `LOCK_N` moves the FSM to `LOCKED`.
  - m < EXP_PERIOD-TOL:
    - `period`=m, `period_valid` and `err_short` pulse.
    - `good`=0, `locked` drops.
    - FSM goes to `TRACK`; the tick starts a new measurement.
- Timeout: in `TRACK` or `LOCKED`, when `cnt` == EXP_PERIOD+TOL:
  - `err_long` pulses and `miss_count` increments, saturating at 255.
  - `good`=0 and the FSM goes to `SYNC`.
  - If `tick_in` is high in that same cycle, it is taken as the first tick: go to `TRACK` with `cnt`=0.
- `enable` low:
  - FSM goes to `SYNC`; `cnt` and `good` are cleared.
  - All strobes and `locked` are forced to 0.
  - `period` and `miss_count` hold.
- `clear` zeroes `miss_count`. It wins over a simultaneous increment.
- `clear` does not affect the FSM.
- Ticks are evaluated only while `enable` is high.

## Timing
- Reset values:
  - FSM in `SYNC`; `cnt`=0, `good`=0.
  - `period`=0, `miss_count`=0.
  - All strobes 0, `locked`=0.
- Latency: all outputs are registered. Strobes and `period` update 1 cycle after the causing `tick_in` or timeout cycle.
- `locked` rises 1 cycle after the `LOCK_N`-th good tick. It falls 1 cycle after an error cycle.
- Asserting reset mid-measurement aborts it immediately and asynchronously. No strobe is issued.
- At most one of `err_short`/`err_long` is high in any cycle. `period_valid` may coincide with `err_short` only.

## Configuration
- `TICK_MON_HIST_EN` defined:
  - Adds outputs `period_min` and `period_max` (CNT_W each), updated on every `period_valid`.
  - Reset values: `period_min`=all ones, `period_max`=0.
  - `clear` also resets them to these values.
- Undefined: these ports and registers are absent. All other behaviour is identical.

## Structure
- Package `tick_mon_pkg`:
  - State enum `tick_mon_state_t` (`SYNC`, `TRACK`, `LOCKED`).
  - Default constants for `EXP_PERIOD`, `TOL`, `LOCK_N`.
  - Miss-counter width 8.
- One sub-module, `tick_sat_cnt`: a parameterised saturating up-counter with synchronous clear. It is used for `miss_count` and `good`.
- FSM, cycle counter and output registers live in the top module.

## Test plan
- Ticks every 1000 cycles, 6 ticks:
  - 5 `period_valid` strobes with `period`=1000.
  - `locked`=1 one cycle after the 5th tick (4 good periods).
  - No errors.
- Locked, then a tick after 990 cycles: `err_short` and `period_valid` with `period`=990, `locked`→0.
- Locked, then ticks stop:
  - `err_long` 1 cycle after `cnt`==1002.
  - `miss_count`=1 and FSM in `SYNC`.
  - The next tick gives no `period_valid`.
- Periods 998, 1002, 1000, 999: all accepted, with `locked`=1 after the 4th.
- `miss_count` at 255 plus one more timeout: stays 255. `clear` together with a timeout → `miss_count`=0.
- `enable` dropped mid-measurement:
  - `locked`=0, no strobes.
  - On re-enable, the first tick gives no `period_valid`.
  - Async reset low mid-period restores all reset values.

Source files
------------

// File: rtl/tick_mon_pkg.sv
// Shared types and default constants for the tick period monitor.
package tick_mon_pkg;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } tick_mon_state_t;

  localparam int unsigned DEF_EXP_PERIOD = 1000;
  localparam int unsigned DEF_TOL        = 2;
  localparam int unsigned DEF_LOCK_N     = 4;
  localparam int unsigned MISS_W         = 8;

endpackage

// File: rtl/tick_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module tick_sat_cnt #(
  parameter int unsigned W   = 8,
  parameter int unsigned MAX = (2 ** W) - 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] count_q, count_d;

  // NOTE: assign the default before any branch so this block never infers a latch.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != MAX_V)) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/tick_period_monitor.sv
// Measures spacing of divider ticks, flags early/late ticks and reports lock.
// Define TICK_MON_HIST_EN to add period_min/period_max history outputs.
module tick_period_monitor
  import tick_mon_pkg::*;
#(
  parameter int unsigned EXP_PERIOD = DEF_EXP_PERIOD,
  parameter int unsigned TOL        = DEF_TOL,
  parameter int unsigned LOCK_N     = DEF_LOCK_N,
  parameter int unsigned CNT_W      = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              tick_in,
  input  logic              clear,
  output logic [CNT_W-1:0]  period,
  output logic              period_valid,
  output logic              err_short,
  output logic              err_long,
  output logic              locked,
  output logic [MISS_W-1:0] miss_count
`ifdef TICK_MON_HIST_EN
  ,
  output logic [CNT_W-1:0]  period_min,
  output logic [CNT_W-1:0]  period_max
`endif
);

  localparam int unsigned      GOOD_W    = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(EXP_PERIOD + TOL);
  localparam logic [CNT_W-1:0] MIN_OK_V  = CNT_W'(EXP_PERIOD - TOL);
  localparam logic [GOOD_W-1:0] LOCK_M1_V = GOOD_W'(LOCK_N - 1);

  tick_mon_state_t   state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic              pv_q, pv_d;
  logic              es_q, es_d;
  logic              el_q, el_d;
  logic [CNT_W-1:0]  measured;
  logic [GOOD_W-1:0] good_cnt;
  logic              good_clr, good_inc, miss_inc;

  assign measured = cnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    pv_d     = 1'b0;
    es_d     = 1'b0;
    el_d     = 1'b0;
    good_clr = 1'b0;
    good_inc = 1'b0;
    miss_inc = 1'b0;
    if (!enable) begin
      state_d  = SYNC;
      cnt_d    = '0;
      good_clr = 1'b1;
    end else begin
      case (state_q)
        SYNC: begin
          if (tick_in) begin
            state_d  = TRACK;
            cnt_d    = '0;
            good_clr = 1'b1;
          end
        end
        TRACK, LOCKED: begin
          cnt_d = cnt_q + 1'b1;
          // A tick in the timeout cycle would measure EXP_PERIOD+TOL+1, so timeout takes priority.
          if (cnt_q == TIMEOUT_V) begin
            el_d     = 1'b1;
            miss_inc = 1'b1;
            good_clr = 1'b1;
            cnt_d    = '0;
            state_d  = tick_in ? TRACK : SYNC;
          end else if (tick_in) begin
            cnt_d    = '0;
            period_d = measured;
            pv_d     = 1'b1;
            if (measured < MIN_OK_V) begin
              es_d     = 1'b1;
              good_clr = 1'b1;
              state_d  = TRACK;
            end else begin
              good_inc = 1'b1;
              if (good_cnt >= LOCK_M1_V) begin
                state_d = LOCKED;
              end
            end
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= SYNC;
      cnt_q    <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      es_q     <= 1'b0;
      el_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      es_q     <= es_d;
      el_q     <= el_d;
    end
  end

  tick_sat_cnt #(
    .W   (GOOD_W),
    .MAX (LOCK_N)
  ) u_good_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .clr_i   (good_clr),
    .inc_i   (good_inc),
    .count_o (good_cnt)
  );

  tick_sat_cnt #(
    .W (MISS_W)
  ) u_miss_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .clr_i   (clear),
    .inc_i   (miss_inc),
    .count_o (miss_count)
  );

`ifdef TICK_MON_HIST_EN
  logic [CNT_W-1:0] min_q, min_d, max_q, max_d;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (clear) begin
      min_d = '1;
      max_d = '0;
    end else if (pv_d) begin
      if (period_d < min_q) min_d = period_d;
      if (period_d > max_q) max_d = period_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign period_min = min_q;
  assign period_max = max_q;
`endif

  assign period       = period_q;
  assign period_valid = pv_q;
  assign err_short    = es_q;
  assign err_long     = el_q;
  assign locked       = (state_q == LOCKED);

endmodule

// File: tb/tb_tick_period_monitor.sv
// Directed bench: default-parameter monitor plus a small-period instance for miss-counter saturation.
module tb_tick_period_monitor;

  logic        clk;
  logic        reset;
  logic        enable, tick_in, clear;
  logic [11:0] period;
  logic        period_valid, err_short, err_long, locked;
  logic [7:0]  miss_count;

  logic        s_enable, s_tick, s_clear;
  logic [4:0]  s_period;
  logic        s_pv, s_es, s_el, s_locked;
  logic [7:0]  s_miss;

`ifdef TICK_MON_HIST_EN
  logic [11:0] period_min, period_max;
  logic [4:0]  s_period_min, s_period_max;
`endif

  int checks   = 0;
  int failures = 0;
  logic stray  = 1'b0;

  tick_period_monitor u_dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .tick_in      (tick_in),
    .clear        (clear),
    .period       (period),
    .period_valid (period_valid),
    .err_short    (err_short),
    .err_long     (err_long),
    .locked       (locked),
    .miss_count   (miss_count)
`ifdef TICK_MON_HIST_EN
    ,
    .period_min   (period_min),
    .period_max   (period_max)
`endif
  );

  tick_period_monitor #(
    .EXP_PERIOD (8),
    .TOL        (1),
    .LOCK_N     (2),
    .CNT_W      (5)
  ) u_small (
    .clk          (clk),
    .reset        (reset),
    .enable       (s_enable),
    .tick_in      (s_tick),
    .clear        (s_clear),
    .period       (s_period),
    .period_valid (s_pv),
    .err_short    (s_es),
    .err_long     (s_el),
    .locked       (s_locked),
    .miss_count   (s_miss)
`ifdef TICK_MON_HIST_EN
    ,
    .period_min   (s_period_min),
    .period_max   (s_period_max)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (period_valid || err_short || err_long) stray = 1'b1;
    end
  endtask

  task automatic pulse();
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
  endtask

  task automatic pulse_s();
    s_tick = 1'b1;
    step();
    s_tick = 1'b0;
  endtask

  int periods[4] = '{998, 1002, 1000, 999};

  initial begin
    reset    = 1'b0;
    enable   = 1'b0;
    tick_in  = 1'b0;
    clear    = 1'b0;
    s_enable = 1'b0;
    s_tick   = 1'b0;
    s_clear  = 1'b0;
    repeat (3) step();

    check("rst_period", period, 0);
    check("rst_pv", period_valid, 0);
    check("rst_es", err_short, 0);
    check("rst_el", err_long, 0);
    check("rst_locked", locked, 0);
    check("rst_miss", miss_count, 0);
`ifdef TICK_MON_HIST_EN
    check("rst_min", period_min, 12'hfff);
    check("rst_max", period_max, 0);
`endif
    reset = 1'b1;

    // Small instance: timeout coinciding with a tick, then miss_count saturation and clear.
    s_enable = 1'b1;
    step();
    pulse_s();
    check("s_sync_no_pv", s_pv, 0);
    repeat (9) step();
    check("s_no_early_timeout", s_el, 0);
    s_tick = 1'b1;
    step();
    s_tick = 1'b0;
    check("s_timeout_el", s_el, 1);
    check("s_timeout_pv", s_pv, 0);
    check("s_miss_1", s_miss, 1);
    repeat (7) step();
    pulse_s();
    check("s_after_timeout_pv", s_pv, 1);
    check("s_after_timeout_period", s_period, 8);

    for (int i = 0; i < 254; i++) begin
      repeat (10) step();
      pulse_s();
    end
    check("s_miss_255", s_miss, 255);
    repeat (10) step();
    check("s_sat_el", s_el, 1);
    check("s_miss_sat", s_miss, 255);
    pulse_s();
    repeat (9) step();
    s_clear = 1'b1;
    step();
    s_clear = 1'b0;
    check("s_clear_el", s_el, 1);
    check("s_clear_wins", s_miss, 0);
    s_enable = 1'b0;

    // Main instance: acquire lock on 1000-cycle ticks.
    enable = 1'b1;
    idle(5);
    pulse();
    check("sync_no_pv", period_valid, 0);
    stray = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      idle(999);
      pulse();
      check("lock_pv", period_valid, 1);
      check("lock_period", period, 1000);
      check("lock_err", {err_short, err_long}, 0);
      check("lock_level", locked, (k >= 4) ? 1 : 0);
    end
    check("lock_no_stray", stray, 0);

    // Early tick breaks lock.
    idle(989);
    pulse();
    check("short_pv", period_valid, 1);
    check("short_es", err_short, 1);
    check("short_el", err_long, 0);
    check("short_period", period, 990);
    check("short_unlock", locked, 0);

    // Tolerance edges re-acquire lock.
    for (int i = 0; i < 4; i++) begin
      idle(periods[i] - 1);
      pulse();
      check("tol_pv", period_valid, 1);
      check("tol_period", period, periods[i]);
      check("tol_es", err_short, 0);
      check("tol_locked", locked, (i == 3) ? 1 : 0);
    end
`ifdef TICK_MON_HIST_EN
    check("hist_min", period_min, 990);
    check("hist_max", period_max, 1002);
`endif

    // Missing tick times out at cnt == 1002.
    stray = 1'b0;
    idle(1002);
    check("timeout_not_early", stray, 0);
    step();
    check("timeout_el", err_long, 1);
    check("timeout_pv", period_valid, 0);
    check("timeout_unlock", locked, 0);
    check("timeout_miss", miss_count, 1);
    idle(50);
    pulse();
    check("post_timeout_no_pv", period_valid, 0);
    idle(999);
    pulse();
    check("post_timeout_pv", period_valid, 1);
    check("post_timeout_period", period, 1000);

    // Enable dropped mid-measurement.
    idle(500);
    enable = 1'b0;
    stray  = 1'b0;
    idle(3);
    check("dis_locked", locked, 0);
    pulse();
    check("dis_tick_pv", period_valid, 0);
    idle(5);
    check("dis_no_stray", stray, 0);
    check("dis_period_hold", period, 1000);
    check("dis_miss_hold", miss_count, 1);
    enable = 1'b1;
    idle(20);
    pulse();
    check("reen_no_pv", period_valid, 0);
    idle(999);
    pulse();
    check("reen_pv", period_valid, 1);
    check("reen_period", period, 1000);

    // Asynchronous reset mid-period.
    idle(300);
    #3;
    reset = 1'b0;
    #1;
    check("areset_period", period, 0);
    check("areset_miss", miss_count, 0);
    check("areset_locked", locked, 0);
    check("areset_pv", period_valid, 0);
    #1;
    reset = 1'b1;
    idle(2);
    pulse();
    check("areset_sync_no_pv", period_valid, 0);
    idle(999);
    pulse();
    check("areset_recover_period", period, 1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
